// File: rtl/gcd_tg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_tg_pkg
//  Description : Shared types and constants for the gcd traffic generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package gcd_tg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } tg_state_t;

    // Taps for x^16+x^14+x^13+x^11+1 on a left-shifting register
    localparam logic [15:0] c_lfsr_taps      = 16'hB400;
    localparam logic [15:0] c_default_seed_a = 16'hACE1;
    localparam logic [15:0] c_default_seed_b = 16'h1D87;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] q);
        return {q[14:0], ^(q & c_lfsr_taps)};
    endfunction

    // An all-zero seed would lock the LFSR, so it falls back to the default
    function automatic logic [15:0] seed_or_default(input logic [15:0] seed,
                                                    input logic [15:0] dflt);
        return (seed == 16'd0) ? dflt : seed;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gcd_tg_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_tg_lfsr16
//  Description : 16-bit Fibonacci LFSR with seed load and single-step advance.
//  Revision    : 1.0 - initial release
// ============================================================================
module gcd_tg_lfsr16
    import gcd_tg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            r_q <= seed;
        end else if (step) begin
            r_q <= lfsr16_next(r_q);
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/gcd_traffic_gen.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_traffic_gen
//  Description : Val/rdy initiator issuing gcd operand pairs and checksumming
//                the results under programmable response backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module gcd_traffic_gen
    import gcd_tg_pkg::*;
#(
    parameter logic [15:0] SEED_A         = 16'hACE1,
    parameter logic [15:0] SEED_B         = 16'h1D87,
    parameter int unsigned RESP_DELAY     = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] num_ops,
    input  logic        use_lfsr,
    input  logic [15:0] cfg_a,
    input  logic [15:0] cfg_b,
    output logic [31:0] req_msg,
    output logic        req_val,
    input  logic        req_rdy,
    input  logic [15:0] resp_msg,
    input  logic        resp_val,
    output logic        resp_rdy,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] op_count,
    output logic [31:0] checksum,
    output logic [15:0] last_result
);

    localparam logic [15:0] c_seed_a     = seed_or_default(SEED_A, c_default_seed_a);
    localparam logic [15:0] c_seed_b     = seed_or_default(SEED_B, c_default_seed_b);
    localparam logic [31:0] c_resp_delay = 32'(RESP_DELAY);
    localparam logic [31:0] c_timeout    = 32'(TIMEOUT_CYCLES);

    tg_state_t   r_state;
    logic [31:0] r_req_msg;
    logic        r_req_val;
    logic        r_resp_rdy;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic [15:0] r_op_count;
    logic [31:0] r_checksum;
    logic [15:0] r_last_result;
    logic [15:0] r_num_ops;
    logic        r_use_lfsr;
    logic [31:0] r_wait_cnt;

    logic        w_lfsr_load;
    logic        w_resp_xfer;
    logic [15:0] w_lfsr_a;
    logic [15:0] w_lfsr_b;
    logic [15:0] w_next_a;
    logic [15:0] w_next_b;

    assign w_lfsr_load = (r_state == IDLE) && start;
    assign w_resp_xfer = (r_state == WAIT) && resp_val && r_resp_rdy;
    assign w_next_a    = lfsr16_next(w_lfsr_a);
    assign w_next_b    = lfsr16_next(w_lfsr_b);

    // Each run restarts the sequences from the seeds so runs are repeatable
    gcd_tg_lfsr16 u_lfsr_a (
        .clk   (clk),
        .reset (reset),
        .load  (w_lfsr_load),
        .seed  (c_seed_a),
        .step  (w_resp_xfer),
        .q     (w_lfsr_a)
    );

    gcd_tg_lfsr16 u_lfsr_b (
        .clk   (clk),
        .reset (reset),
        .load  (w_lfsr_load),
        .seed  (c_seed_b),
        .step  (w_resp_xfer),
        .q     (w_lfsr_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_req_msg     <= 32'd0;
            r_req_val     <= 1'b0;
            r_resp_rdy    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_op_count    <= 16'd0;
            r_checksum    <= 32'd0;
            r_last_result <= 16'd0;
            r_num_ops     <= 16'd0;
            r_use_lfsr    <= 1'b0;
            r_wait_cnt    <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_op_count <= 16'd0;
                        r_checksum <= 32'd0;
                        r_num_ops  <= num_ops;
                        r_use_lfsr <= use_lfsr;
                        r_req_msg  <= use_lfsr ? {c_seed_b, c_seed_a} : {cfg_b, cfg_a};
                        r_busy     <= 1'b1;
                        if (num_ops == 16'd0) begin
                            r_state <= DONE;
                        end else begin
                            r_state   <= SEND;
                            r_req_val <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (req_rdy) begin
                        r_req_val  <= 1'b0;
                        r_wait_cnt <= 32'd0;
                        r_resp_rdy <= (c_resp_delay == 32'd0);
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_val && r_resp_rdy) begin
                        r_checksum    <= r_checksum + {16'd0, resp_msg};
                        r_last_result <= resp_msg;
                        r_op_count    <= r_op_count + 16'd1;
                        r_resp_rdy    <= 1'b0;
                        if (r_op_count + 16'd1 == r_num_ops) begin
                            r_state <= DONE;
                        end else begin
                            r_state   <= SEND;
                            r_req_val <= 1'b1;
                            // Fixed mode simply reissues the captured operands
                            if (r_use_lfsr) begin
                                r_req_msg <= {w_next_b, w_next_a};
                            end
                        end
                    end else if (r_wait_cnt + 32'd1 >= c_timeout) begin
                        r_error    <= 1'b1;
                        r_resp_rdy <= 1'b0;
                        r_state    <= DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                        if (r_wait_cnt + 32'd1 == c_resp_delay) begin
                            r_resp_rdy <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_msg     = r_req_msg;
    assign req_val     = r_req_val;
    assign resp_rdy    = r_resp_rdy;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign op_count    = r_op_count;
    assign checksum    = r_checksum;
    assign last_result = r_last_result;

endmodule
`default_nettype wire

// File: tb/tb_gcd_traffic_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gcd_traffic_gen
//  Description : Self-checking bench with a gcd responder model and scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_traffic_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_ops;
    logic        use_lfsr;
    logic [15:0] cfg_a;
    logic [15:0] cfg_b;
    logic [31:0] req_msg;
    logic        req_val;
    logic        req_rdy;
    logic [15:0] resp_msg;
    logic        resp_val;
    logic        resp_rdy;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] op_count;
    logic [31:0] checksum;
    logic [15:0] last_result;

    int checks = 0;
    int errors = 0;

    int req_stall   = 0;
    bit resp_enable = 1'b1;

    logic [15:0] rsp_q[$];
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];
    logic [31:0] sent_q[$];
    logic [31:0] exp_req_q[$];

    always #5 clk = ~clk;

    gcd_traffic_gen #(
        .SEED_A         (16'hACE1),
        .SEED_B         (16'h1D87),
        .RESP_DELAY     (6),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_ops     (num_ops),
        .use_lfsr    (use_lfsr),
        .cfg_a       (cfg_a),
        .cfg_b       (cfg_b),
        .req_msg     (req_msg),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .resp_msg    (resp_msg),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .op_count    (op_count),
        .checksum    (checksum),
        .last_result (last_result)
    );

    function automatic logic [15:0] gcd16(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] t;
        a = x;
        b = y;
        while (b != 16'd0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    // gcd unit model: one outstanding request, answers as soon as enabled
    initial begin : responder
        bit          p_req;
        bit          p_resp;
        logic [31:0] p_msg;
        int          hold;
        p_req = 0; p_resp = 0; p_msg = 32'd0; hold = 0;
        req_rdy = 1'b0; resp_val = 1'b0; resp_msg = 16'd0;
        forever begin
            @(negedge clk);
            if (p_req) begin
                sent_q.push_back(p_msg);
                rsp_q.push_back(gcd16(p_msg[15:0], p_msg[31:16]));
                hold = 0;
            end
            if (p_resp) begin
                obs_q.push_back(resp_msg);
                resp_val = 1'b0;
            end
            if (reset) begin
                rsp_q.delete();
                resp_val = 1'b0;
                hold = 0;
            end
            if (!resp_val && resp_enable && rsp_q.size() > 0) begin
                resp_msg = rsp_q.pop_front();
                resp_val = 1'b1;
            end
            req_rdy = req_val && (hold >= req_stall);
            if (req_val && !req_rdy) hold++;
            p_req  = req_val && req_rdy && !reset;
            p_msg  = req_msg;
            p_resp = resp_val && resp_rdy && !reset;
        end
    end

    task automatic start_run(input logic [15:0] n, input logic lf,
                             input logic [15:0] a, input logic [15:0] b);
        num_ops = n; use_lfsr = lf; cfg_a = a; cfg_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (done && !busy) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; num_ops = 16'd0; use_lfsr = 1'b0;
        cfg_a = 16'd0; cfg_b = 16'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_val, resp_rdy, busy, done, error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {req_val, resp_rdy, busy, done, error});
        end
        checks++;
        if (req_msg !== 32'd0) begin
            errors++;
            $display("FAIL reset_req_msg: got %h expected 0", req_msg);
        end
        checks++;
        if (op_count !== 16'd0 || checksum !== 32'd0 || last_result !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", op_count, checksum, last_result);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fixed_single();
        bit ok;
        logic [15:0] e;
        logic [31:0] er;
        exp_q.push_back(16'd15);
        exp_req_q.push_back({16'd150, 16'd15});
        start_run(16'd1, 1'b0, 16'd15, 16'd150);
        wait_done(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t1_timeout: got no done expected done within 200 cycles"); end
        checks++;
        if (checksum !== 32'd15) begin errors++; $display("FAIL t1_checksum: got %0d expected 15", checksum); end
        checks++;
        if (op_count !== 16'd1) begin errors++; $display("FAIL t1_op_count: got %0d expected 1", op_count); end
        checks++;
        if ({done, error} !== 2'b10) begin errors++; $display("FAIL t1_done_error: got %b expected 10", {done, error}); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL t1_resp: got none expected %0d", e); end
            else if (obs_q[0] !== e) begin errors++; $display("FAIL t1_resp: got %0d expected %0d", obs_q.pop_front(), e); end
            else void'(obs_q.pop_front());
        end
        while (exp_req_q.size() > 0) begin
            er = exp_req_q.pop_front();
            checks++;
            if (sent_q.size() == 0) begin errors++; $display("FAIL t1_req: got none expected %h", er); end
            else if (sent_q[0] !== er) begin errors++; $display("FAIL t1_req: got %h expected %h", sent_q.pop_front(), er); end
            else void'(sent_q.pop_front());
        end
    endtask

    task automatic test_fixed_multi();
        bit ok;
        logic [15:0] e;
        logic [31:0] er;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(16'd2);
            exp_req_q.push_back(32'h086E_1316);
        end
        start_run(16'd3, 1'b0, 16'd4886, 16'd2158);
        wait_done(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t2_timeout: got no done expected done within 300 cycles"); end
        checks++;
        if (checksum !== 32'd6) begin errors++; $display("FAIL t2_checksum: got %0d expected 6", checksum); end
        checks++;
        if (op_count !== 16'd3 || last_result !== 16'd2) begin
            errors++;
            $display("FAIL t2_count_last: got %0d/%0d expected 3/2", op_count, last_result);
        end
        checks++;
        if (req_msg !== 32'h086E_1316) begin errors++; $display("FAIL t2_req_msg: got %h expected 086e1316", req_msg); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL t2_resp: got none expected %0d", e); end
            else if (obs_q[0] !== e) begin errors++; $display("FAIL t2_resp: got %0d expected %0d", obs_q.pop_front(), e); end
            else void'(obs_q.pop_front());
        end
        while (exp_req_q.size() > 0) begin
            er = exp_req_q.pop_front();
            checks++;
            if (sent_q.size() == 0) begin errors++; $display("FAIL t2_req: got none expected %h", er); end
            else if (sent_q[0] !== er) begin errors++; $display("FAIL t2_req: got %h expected %h", sent_q.pop_front(), er); end
            else void'(sent_q.pop_front());
        end
    endtask

    task automatic test_req_stall();
        bit ok;
        int bad;
        logic [31:0] first_msg;
        req_stall = 20;
        start_run(16'd1, 1'b0, 16'd15, 16'd150);
        first_msg = req_msg;
        bad = 0;
        for (int i = 0; i <= 20; i++) begin
            if (req_val !== 1'b1 || req_msg !== first_msg) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0 || first_msg !== 32'h0096_000F) begin
            errors++;
            $display("FAIL t3_stall_hold: got %0d unstable cycles msg %h expected 0 and 0096000f", bad, first_msg);
        end
        checks++;
        if (req_val !== 1'b0) begin errors++; $display("FAIL t3_accept: got req_val %b expected 0 after cycle 21", req_val); end
        wait_done(200, ok);
        req_stall = 0;
        checks++;
        if (!ok || op_count !== 16'd1) begin errors++; $display("FAIL t3_complete: got done %b op_count %0d expected 1/1", ok, op_count); end
        obs_q.delete(); sent_q.delete();
    endtask

    task automatic test_resp_delay();
        bit ok;
        int n;
        int k;
        start_run(16'd1, 1'b0, 16'd15, 16'd150);
        n = 0;
        while (req_val === 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (req_val !== 1'b0) begin errors++; $display("FAIL t4_enter_wait: got req_val %b expected 0", req_val); end
        k = 0;
        while (resp_rdy !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        checks++;
        if (k != 6) begin errors++; $display("FAIL t4_resp_delay: got %0d cycles expected 6", k); end
        checks++;
        if (resp_val !== 1'b1) begin errors++; $display("FAIL t4_resp_val_early: got %b expected 1", resp_val); end
        wait_done(200, ok);
        checks++;
        if (!ok || last_result !== 16'd15) begin errors++; $display("FAIL t4_complete: got %0d expected 15", last_result); end
        obs_q.delete(); sent_q.delete();
    endtask

    task automatic test_timeout();
        bit ok;
        resp_enable = 1'b0;
        start_run(16'd1, 1'b0, 16'd15, 16'd150);
        wait_done(200, ok);
        checks++;
        if (!ok || {done, error} !== 2'b11) begin
            errors++;
            $display("FAIL t5_error: got done %b error %b expected 1/1", done, error);
        end
        checks++;
        if (op_count !== 16'd0 || checksum !== 32'd0) begin
            errors++;
            $display("FAIL t5_counts: got %0d/%0d expected 0/0", op_count, checksum);
        end
        rsp_q.delete(); sent_q.delete();
        resp_enable = 1'b1;
        start_run(16'd1, 1'b0, 16'd15, 16'd150);
        checks++;
        if ({done, error} !== 2'b00) begin errors++; $display("FAIL t5_clear: got %b expected 00", {done, error}); end
        wait_done(200, ok);
        checks++;
        if (!ok || error !== 1'b0 || checksum !== 32'd15) begin
            errors++;
            $display("FAIL t5_rerun: got error %b checksum %0d expected 0/15", error, checksum);
        end
        obs_q.delete(); sent_q.delete();
    endtask

    task automatic test_lfsr();
        bit ok;
        logic [15:0] ma;
        logic [15:0] mb;
        logic [15:0] e;
        logic [31:0] er;
        logic [31:0] sum;
        ma = 16'hACE1; mb = 16'h1D87; sum = 32'd0;
        for (int i = 0; i < 4; i++) begin
            exp_req_q.push_back({mb, ma});
            exp_q.push_back(gcd16(ma, mb));
            sum = sum + {16'd0, gcd16(ma, mb)};
            ma = lfsr_step(ma);
            mb = lfsr_step(mb);
        end
        start_run(16'd4, 1'b1, 16'd0, 16'd0);
        wait_done(400, ok);
        checks++;
        if (!ok || op_count !== 16'd4) begin errors++; $display("FAIL lfsr_done: got op_count %0d expected 4", op_count); end
        checks++;
        if (checksum !== sum) begin errors++; $display("FAIL lfsr_checksum: got %0d expected %0d", checksum, sum); end
        while (exp_req_q.size() > 0) begin
            er = exp_req_q.pop_front();
            checks++;
            if (sent_q.size() == 0) begin errors++; $display("FAIL lfsr_req: got none expected %h", er); end
            else if (sent_q[0] !== er) begin errors++; $display("FAIL lfsr_req: got %h expected %h", sent_q.pop_front(), er); end
            else void'(sent_q.pop_front());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL lfsr_resp: got none expected %0d", e); end
            else if (obs_q[0] !== e) begin errors++; $display("FAIL lfsr_resp: got %0d expected %0d", obs_q.pop_front(), e); end
            else void'(obs_q.pop_front());
        end
    endtask

    task automatic test_zero_ops();
        start_run(16'd0, 1'b0, 16'd7, 16'd9);
        checks++;
        if ({busy, done, req_val} !== 3'b100) begin
            errors++;
            $display("FAIL t6_zero_first: got busy/done/req_val %b expected 100", {busy, done, req_val});
        end
        @(negedge clk);
        checks++;
        if ({busy, done, req_val} !== 3'b010 || sent_q.size() != 0) begin
            errors++;
            $display("FAIL t6_zero_done: got %b sent %0d expected 010 sent 0", {busy, done, req_val}, sent_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int n;
        resp_enable = 1'b0;
        start_run(16'd1, 1'b0, 16'd15, 16'd150);
        n = 0;
        while (req_val === 1'b1 && n < 50) begin @(negedge clk); n++; end
        repeat (7) @(negedge clk);
        checks++;
        if (resp_rdy !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t6_in_wait: got resp_rdy %b busy %b expected 1/1", resp_rdy, busy);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({req_val, resp_rdy, busy, done, error} !== 5'b0 || req_msg !== 32'd0) begin
            errors++;
            $display("FAIL t6_reset_flags: got %b msg %h expected 00000 msg 0", {req_val, resp_rdy, busy, done, error}, req_msg);
        end
        checks++;
        if (op_count !== 16'd0 || checksum !== 32'd0 || last_result !== 16'd0) begin
            errors++;
            $display("FAIL t6_reset_counters: got %0d/%0d/%0d expected 0/0/0", op_count, checksum, last_result);
        end
        reset = 1'b0;
        @(negedge clk);
        resp_enable = 1'b1;
        sent_q.delete(); obs_q.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_fixed_single();
        test_fixed_multi();
        test_req_stall();
        test_resp_delay();
        test_timeout();
        test_lfsr();
        test_zero_ops();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
